// File: rtl/sequencer_pkg.sv
// sequencer_pkg: opcodes, entry-word field ranges, FSM states and fault codes for register_sequencer.
package sequencer_pkg;
  localparam logic [7:0] OP_END   = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 24;
  localparam int DEV_HI = 23;
  localparam int DEV_LO = 16;
  localparam int REG_HI = 15;
  localparam int REG_LO = 8;
  localparam int WD_HI  = 7;
  localparam int WD_LO  = 0;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, NEXT, FAULT} state_e;
  typedef enum logic [3:0] {
    FC_NONE     = 4'd0,
    FC_MEM      = 4'd1,
    FC_OPCODE   = 4'd2,
    FC_BUS      = 4'd3,
    FC_OVERRUN  = 4'd4,
    FC_TIMEOUT  = 4'd5
  } fault_e;
endpackage

// File: rtl/register_sequencer.sv
// register_sequencer: walks the register_memory transaction list and issues each entry to the I2C master.
module register_sequencer
  import sequencer_pkg::*;
#(
  parameter int MEMORY_SIZE = 255,
  parameter int RSP_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  reg_addr,
  input  logic [31:0] read_data,
  input  logic [3:0]  error_code,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic [7:0]  cmd_dev_addr,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_error,
  output logic        rd_valid,
  output logic [7:0]  rd_reg,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [3:0]  fault_code
);
  localparam int CW = $clog2(RSP_TIMEOUT + 1);
  state_e state, nxt;
  fault_e fc, pcode;
  logic [CW-1:0] cnt;
  logic [7:0] op;
  logic is_rw, last, timeout;
  assign op      = read_data[OP_HI:OP_LO];
  assign is_rw   = (op == OP_READ) || (op == OP_WRITE);
  assign last    = reg_addr == 8'(MEMORY_SIZE - 1);
  assign timeout = cnt == CW'(RSP_TIMEOUT - 1);
  always_comb begin
    nxt = state;
    fc  = FC_NONE;
    case (state)
      IDLE:     nxt = start ? FETCH : IDLE;
      FETCH:    nxt = DECODE;
      DECODE: begin
        nxt = (error_code != 4'd0 || !(is_rw || op == OP_END)) ? FAULT : (op == OP_END) ? IDLE : ISSUE;
        fc  = (error_code != 4'd0) ? FC_MEM : FC_OPCODE;
      end
      ISSUE:    nxt = cmd_ready ? WAIT_RSP : ISSUE;
      WAIT_RSP: begin
        // a response arriving on the expiry edge takes priority over the timeout
        nxt = rsp_valid ? (rsp_error ? FAULT : NEXT) : timeout ? FAULT : WAIT_RSP;
        fc  = rsp_valid ? FC_BUS : FC_TIMEOUT;
      end
      NEXT: begin
        nxt = last ? FAULT : FETCH;
        fc  = FC_OVERRUN;
      end
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pcode        <= FC_NONE;
      cnt          <= '0;
      reg_addr     <= '0;
      cmd_valid    <= 1'b0;
      cmd_rw       <= 1'b0;
      cmd_dev_addr <= '0;
      cmd_reg      <= '0;
      cmd_wdata    <= '0;
      rd_valid     <= 1'b0;
      rd_reg       <= '0;
      rd_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= '0;
    end else begin
      state    <= nxt;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (nxt == FAULT) pcode <= fc;
      case (state)
        IDLE: if (start) begin
          reg_addr   <= '0;
          fault      <= 1'b0;
          fault_code <= '0;
          busy       <= 1'b1;
        end
        DECODE: begin
          if (nxt == ISSUE) begin
            cmd_valid    <= 1'b1;
            cmd_rw       <= op == OP_READ;
            cmd_dev_addr <= read_data[DEV_HI:DEV_LO];
            cmd_reg      <= read_data[REG_HI:REG_LO];
            cmd_wdata    <= read_data[WD_HI:WD_LO];
          end
          if (nxt == IDLE) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          if (cmd_ready) cmd_valid <= 1'b0;
          cnt <= '0;
        end
        WAIT_RSP: begin
          if (rsp_valid && !rsp_error && cmd_rw) begin
            rd_valid <= 1'b1;
            rd_reg   <= cmd_reg;
            rd_data  <= rsp_data;
          end
          cnt <= (cnt == CW'(RSP_TIMEOUT)) ? cnt : cnt + CW'(1);
        end
        NEXT: if (!last) reg_addr <= reg_addr + 8'd1;
        FAULT: begin
          fault      <= 1'b1;
          fault_code <= pcode;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_register_sequencer.sv
// tb_register_sequencer: directed checks of register_sequencer against a memory and I2C master model.
module tb_register_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  reg_addr;
  logic [31:0] read_data = '0;
  logic [3:0]  error_code = '0;
  logic        cmd_valid, cmd_rw;
  logic        cmd_ready = 1'b1;
  logic [7:0]  cmd_dev_addr, cmd_reg, cmd_wdata;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_data = '0;
  logic        rsp_error = 1'b0;
  logic        rd_valid, busy, done, fault;
  logic [7:0]  rd_reg, rd_data;
  logic [3:0]  fault_code;

  register_sequencer #(.MEMORY_SIZE(5), .RSP_TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start), .reg_addr(reg_addr), .read_data(read_data),
    .error_code(error_code), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .rd_valid(rd_valid), .rd_reg(rd_reg),
    .rd_data(rd_data), .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic        rsp_en = 1'b1, err_on = 1'b0, pend = 1'b0;
  logic [7:0]  err_reg = '0, pend_reg = '0;
  logic        log_rw [64];
  logic [7:0]  log_reg [64], log_wd [64], rlog_reg [64], rlog_data [64];
  int ncmd = 0, nrd = 0, ndone = 0, nhi = 0;
  int total = 0, bad = 0;

  function automatic logic [7:0] dev_byte(input logic [7:0] r);
    return r == 8'h00 ? 8'hE5 : r == 8'h32 ? 8'h12 : r == 8'h33 ? 8'h34 : 8'h00;
  endfunction

  always @(posedge clk) read_data <= mem[reg_addr];

  always @(posedge clk) begin
    rsp_valid <= 1'b0;
    if (cmd_valid && cmd_ready) begin
      pend <= 1'b1;
      pend_reg <= cmd_reg;
      log_rw[ncmd % 64] <= cmd_rw;
      log_reg[ncmd % 64] <= cmd_reg;
      log_wd[ncmd % 64] <= cmd_wdata;
      ncmd <= ncmd + 1;
    end
    if (pend && rsp_en) begin
      rsp_valid <= 1'b1;
      rsp_data  <= dev_byte(pend_reg);
      rsp_error <= err_on && pend_reg == err_reg;
      pend      <= 1'b0;
    end
    if (rd_valid) begin
      rlog_reg[nrd % 64]  <= rd_reg;
      rlog_data[nrd % 64] <= rd_data;
      nrd <= nrd + 1;
    end
    if (done) ndone <= ndone + 1;
    if (busy && reg_addr > 8'd1) nhi <= nhi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_std();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h01_1D_00_00;
    mem[1] = 32'h02_1D_2D_08;
    mem[2] = 32'h01_1D_32_00;
    mem[3] = 32'h01_1D_33_00;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    for (int i = 0; i < lim && busy; i++) @(negedge clk);
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_std_run(input string tag, input int c0, input int r0);
    chk({tag, "_ncmd"}, ncmd - c0, 4);
    chk({tag, "_regs"}, {log_reg[c0], log_reg[c0+1], log_reg[c0+2], log_reg[c0+3]}, 32'h00_2D_32_33);
    chk({tag, "_rw"}, {28'd0, log_rw[c0], log_rw[c0+1], log_rw[c0+2], log_rw[c0+3]}, 32'hB);
    chk({tag, "_wdata"}, {24'd0, log_wd[c0+1]}, 32'h08);
    chk({tag, "_nrd"}, nrd - r0, 3);
    chk({tag, "_rd0"}, {16'd0, rlog_reg[r0], rlog_data[r0]}, 32'h00E5);
    chk({tag, "_rd1"}, {16'd0, rlog_reg[r0+1], rlog_data[r0+1]}, 32'h3212);
    chk({tag, "_rd2"}, {16'd0, rlog_reg[r0+2], rlog_data[r0+2]}, 32'h3334);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    int c0, r0, d0, h0;
    logic stable;
    load_std();
    repeat (3) @(negedge clk);
    chk("rst_ctl", {14'd0, reg_addr, cmd_valid, cmd_rw, rd_valid, busy, done, fault, fault_code}, 32'd0);
    chk("rst_data", {cmd_dev_addr, cmd_reg, cmd_wdata, rd_reg}, 32'd0);
    reset = 1'b0;

    c0 = ncmd; r0 = nrd; d0 = ndone;
    pulse_start();
    chk("start_busy_addr", {23'd0, busy, reg_addr}, 32'h100);
    @(negedge clk) chk("fetch_no_cmd", {31'd0, cmd_valid}, 32'd0);
    @(negedge clk) chk("first_cmd", {22'd0, cmd_valid, cmd_rw, cmd_reg}, 32'h300);
    chk("first_dev", {24'd0, cmd_dev_addr}, 32'h1D);
    wait_idle("std_idle", 200);
    @(negedge clk);
    chk_std_run("std", c0, r0);
    chk("std_done", ndone - d0, 1);

    c0 = ncmd; r0 = nrd;
    cmd_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 10 && !cmd_valid; i++) @(negedge clk);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stable &= cmd_valid && cmd_rw && cmd_dev_addr == 8'h1D && cmd_reg == 8'h00 && cmd_wdata == 8'h00;
      @(negedge clk);
    end
    chk("stall_stable", {31'd0, stable}, 32'd1);
    chk("stall_no_xfer", ncmd - c0, 0);
    cmd_ready = 1'b1;
    wait_idle("stall_idle", 200);
    @(negedge clk);
    chk_std_run("stall", c0, r0);

    c0 = ncmd;
    mem[0] = 32'h05_1D_00_00;
    pulse_start();
    wait_idle("op_idle", 50);
    chk("op_fault", {27'd0, fault, fault_code}, 32'h12);
    chk("op_no_cmd", ncmd - c0, 0);
    load_std();

    error_code = 4'h3;
    pulse_start();
    wait_idle("mem_idle", 50);
    chk("mem_fault", {27'd0, fault, fault_code}, 32'h11);
    error_code = 4'h0;

    c0 = ncmd; h0 = nhi;
    err_on = 1'b1; err_reg = 8'h2D;
    pulse_start();
    wait_idle("bus_idle", 200);
    @(negedge clk);
    chk("bus_fault", {27'd0, fault, fault_code}, 32'h13);
    chk("bus_ncmd", ncmd - c0, 2);
    chk("bus_no_later_fetch", nhi - h0, 0);
    err_on = 1'b0;

    rsp_en = 1'b0;
    pulse_start();
    wait_idle("to_idle", 100);
    chk("to_fault", {27'd0, fault, fault_code}, 32'h15);
    c0 = ncmd; r0 = nrd; d0 = ndone;
    rsp_en = 1'b1;
    pulse_start();
    chk("rerun_clear", {23'd0, fault, reg_addr}, 32'd0);
    wait_idle("rerun_idle", 200);
    @(negedge clk);
    chk_std_run("rerun", c0, r0);
    chk("rerun_done", ndone - d0, 1);

    c0 = ncmd;
    cmd_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 10 && !cmd_valid; i++) @(negedge clk);
    chk("in_issue", {31'd0, cmd_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", {14'd0, reg_addr, cmd_valid, cmd_rw, rd_valid, busy, done, fault, fault_code}, 32'd0);
    chk("midrst_data", {cmd_dev_addr, cmd_reg, cmd_wdata, rd_reg}, 32'd0);
    chk("midrst_rddata", {24'd0, rd_data}, 32'd0);
    reset = 1'b0;
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("midrst_no_xfer", ncmd - c0, 0);

    c0 = ncmd; d0 = ndone;
    mem[4] = 32'h01_1D_00_00;
    pulse_start();
    wait_idle("ovr_idle", 300);
    @(negedge clk);
    chk("ovr_fault", {27'd0, fault, fault_code}, 32'h14);
    chk("ovr_ncmd", ncmd - c0, 5);
    chk("ovr_no_done", ndone - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
